// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC redirect controller.
// Holds the controller state encoding, the redirect source codes (numeric order
// is the arbitration priority) and the redirect record carried between the arbiter and the top.
package pc_ctrl_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Redirect sources. A larger code always wins, so priority compares are plain >=.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JAL  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } src_e;

  // One redirect: valid flag, originating source and raw (unaligned) target.
  typedef struct packed {
    logic        vld;
    src_e        src;
    logic [31:0] tgt;
  } redirect_t;

  // Value driven on jumpVect whenever no jump is being taken.
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // Width of the boot delay counter (BOOT_DELAY is limited to 1..15).
  localparam int unsigned BOOT_CNT_W = 4;

  // Force a target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  // Traps and branches resolve past ID, so the ID/EX instruction is wrong-path too.
  function automatic logic kills_id(input src_e src);
    return (src == SRC_TRAP) || (src == SRC_BR);
  endfunction

endpackage

// File: rtl/redirect_arb.sv
// redirect_arb: combinational 3-way redirect priority select plus pending compare.
// Ports: trap/br/jal request + target inputs, pend_i (held redirect), live_o (live
// winner), live_wins_o (live winner outranks or ties the pending entry), eff_o (redirect to act on).
module redirect_arb
  import pc_ctrl_pkg::*;
(
  input  logic        trap_req_i,
  input  logic [31:0] trap_tgt_i,
  input  logic        br_req_i,
  input  logic [31:0] br_tgt_i,
  input  logic        jal_req_i,
  input  logic [31:0] jal_tgt_i,
  input  redirect_t   pend_i,
  output redirect_t   live_o,
  output logic        live_wins_o,
  output redirect_t   eff_o
);

  src_e pend_prio;

  // Highest-priority live request.
  always_comb begin
    live_o = '0;
    if (trap_req_i) begin
      live_o.vld = 1'b1;
      live_o.src = SRC_TRAP;
      live_o.tgt = trap_tgt_i;
    end else if (br_req_i) begin
      live_o.vld = 1'b1;
      live_o.src = SRC_BR;
      live_o.tgt = br_tgt_i;
    end else if (jal_req_i) begin
      live_o.vld = 1'b1;
      live_o.src = SRC_JAL;
      live_o.tgt = jal_tgt_i;
    end
  end

  // An empty pending slot ranks as NONE so any live request beats it.
  assign pend_prio   = pend_i.vld ? pend_i.src : SRC_NONE;

  // Ties go to the live request: it is the younger, architecturally correct redirect.
  assign live_wins_o = live_o.vld && (live_o.src >= pend_prio);

  always_comb begin
    eff_o = '0;
    if (live_wins_o) begin
      eff_o = live_o;
    end else if (pend_i.vld) begin
      eff_o = pend_i;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequences the PC register (stall / jumpEn / jumpVect) and IF/ID flushes.
// Ports: clk, reset (async, active-high); imemReady, hazardStall; trap/branch/jal requests with
// targets in; stall, jumpEn, jumpVect, flushIF, flushID, imemReq, misalignErr out.
// Redirects that arrive while fetch is stalled by BOOT or an imem wait are held in a
// single pending slot and applied on the first unstalled cycle.
module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_DELAY = 2
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        imemReady,
  input  logic        hazardStall,
  input  logic        trapReq,
  input  logic [31:0] trapVect,
  input  logic        brTaken,
  input  logic [31:0] brTarget,
  input  logic        jalEn,
  input  logic [31:0] jalTarget,
  output logic        stall,
  output logic        jumpEn,
  output logic [31:0] jumpVect,
  output logic        flushIF,
  output logic        flushID,
  output logic        imemReq,
  output logic        misalignErr
);

  state_e                state_q;
  logic [BOOT_CNT_W-1:0] cnt_q;
  redirect_t             pend_q, pend_d;
  logic                  misalign_q;

  redirect_t             live;
  redirect_t             eff;
  logic                  live_wins;
  logic                  in_boot;
  logic                  fetch_stall;

  redirect_arb u_arb (
    .trap_req_i  (trapReq),
    .trap_tgt_i  (trapVect),
    .br_req_i    (brTaken),
    .br_tgt_i    (brTarget),
    .jal_req_i   (jalEn),
    .jal_tgt_i   (jalTarget),
    .pend_i      (pend_q),
    .live_o      (live),
    .live_wins_o (live_wins),
    .eff_o       (eff)
  );

  assign in_boot     = (state_q == ST_BOOT);

  // Stalls during which redirects must be held rather than applied.
  assign fetch_stall = in_boot | ~imemReady;

  // A redirect cancels a hazard stall: the stalled load is on the wrong path.
  assign stall       = fetch_stall | (hazardStall & ~eff.vld);
  assign jumpEn      = eff.vld & ~stall;
  assign jumpVect    = jumpEn ? word_align(eff.tgt) : RESET_VECTOR;
  assign flushIF     = jumpEn | in_boot;
  assign flushID     = (jumpEn & kills_id(eff.src)) | in_boot;
  assign imemReq     = ~in_boot;
  assign misalignErr = misalign_q;

  // Pending slot: consumed by any taken jump; otherwise refilled by a live
  // request that outranks (or ties) it while fetch is held. A lower-priority
  // live request is wrong-path and simply not recorded.
  always_comb begin
    pend_d = pend_q;
    if (jumpEn) begin
      pend_d = '0;
    end else if (fetch_stall && live_wins) begin
      pend_d = live;
    end
  end

  // Boot countdown and RUN/WAIT tracking. BOOT lasts exactly BOOT_DELAY cycles:
  // the count is loaded at reset and RUN is entered on the edge that takes it to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= BOOT_CNT_W'(BOOT_DELAY);
    end else begin
      case (state_q)
        ST_BOOT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= BOOT_CNT_W'(1)) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!imemReady) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imemReady) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          cnt_q   <= BOOT_CNT_W'(BOOT_DELAY);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      // Reported against the raw target, before word alignment.
      misalign_q <= jumpEn & (eff.tgt[1:0] != 2'b00);
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  localparam int BOOT_DELAY = 2;

  typedef struct packed {
    logic        rdy, haz, trap, br, jal;
    logic [31:0] tv, bt, jt;
  } in_t;

  typedef struct packed {
    logic        stall, jen;
    logic [31:0] jv;
    logic        fif, fid, req, mis;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReady, hazardStall, trapReq, brTaken, jalEn;
  logic [31:0] trapVect, brTarget, jalTarget;
  logic        stall, jumpEn, flushIF, flushID, imemReq, misalignErr;
  logic [31:0] jumpVect;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.BOOT_DELAY(BOOT_DELAY)) dut (
    .clk         (clk),
    .reset       (reset),
    .imemReady   (imemReady),
    .hazardStall (hazardStall),
    .trapReq     (trapReq),
    .trapVect    (trapVect),
    .brTaken     (brTaken),
    .brTarget    (brTarget),
    .jalEn       (jalEn),
    .jalTarget   (jalTarget),
    .stall       (stall),
    .jumpEn      (jumpEn),
    .jumpVect    (jumpVect),
    .flushIF     (flushIF),
    .flushID     (flushID),
    .imemReq     (imemReq),
    .misalignErr (misalignErr)
  );

  // ---------------- reference model (spec-level) ----------------
  int          m_boot;     // BOOT cycles still to go
  bit          m_pv;       // pending valid
  int          m_pp;       // pending priority (1 jal, 2 branch, 3 trap)
  logic [31:0] m_pt;       // pending raw target
  bit          m_mis;      // misalign pulse due this cycle
  int          s_lp;
  logic [31:0] s_lt;
  logic [31:0] s_et;
  bit          s_jen, s_hold;

  task automatic model_reset();
    m_boot = BOOT_DELAY;
    m_pv   = 0;
    m_pp   = 0;
    m_pt   = '0;
    m_mis  = 0;
  endtask

  task automatic model_eval(input in_t v, output out_t e);
    int  pp, ep;
    bit  boot;
    s_lp = v.trap ? 3 : v.br ? 2 : v.jal ? 1 : 0;
    s_lt = v.trap ? v.tv : v.br ? v.bt : v.jt;
    pp   = m_pv ? m_pp : 0;
    if (s_lp > 0 && s_lp >= pp) begin
      ep = s_lp; s_et = s_lt;
    end else if (m_pv) begin
      ep = m_pp; s_et = m_pt;
    end else begin
      ep = 0; s_et = '0;
    end
    boot    = (m_boot > 0);
    s_hold  = boot || !v.rdy;
    e.stall = s_hold || (v.haz && ep == 0);
    s_jen   = (ep != 0) && !e.stall;
    e.jen   = s_jen;
    e.jv    = s_jen ? {s_et[31:2], 2'b00} : 32'h0;
    e.fif   = s_jen || boot;
    e.fid   = (s_jen && ep >= 2) || boot;
    e.req   = !boot;
    e.mis   = m_mis;
  endtask

  task automatic model_commit();
    m_mis = s_jen && (s_et[1:0] != 2'b00);
    if (s_jen) begin
      m_pv = 0;
    end else if (s_hold && s_lp > 0 && s_lp >= (m_pv ? m_pp : 0)) begin
      m_pv = 1; m_pp = s_lp; m_pt = s_lt;
    end
    if (m_boot > 0) m_boot--;
  endtask

  // ---------------- helpers ----------------
  function automatic in_t mki(logic rdy, logic haz, logic tr, logic br, logic jl,
                              logic [31:0] tv, logic [31:0] bt, logic [31:0] jt);
    in_t v;
    v.rdy = rdy; v.haz = haz; v.trap = tr; v.br = br; v.jal = jl;
    v.tv = tv; v.bt = bt; v.jt = jt;
    return v;
  endfunction

  function automatic out_t mko(logic st, logic je, logic [31:0] jv,
                               logic fi, logic fd, logic rq, logic ms);
    out_t o;
    o.stall = st; o.jen = je; o.jv = jv; o.fif = fi; o.fid = fd; o.req = rq; o.mis = ms;
    return o;
  endfunction

  function automatic out_t sample();
    return mko(stall, jumpEn, jumpVect, flushIF, flushID, imemReq, misalignErr);
  endfunction

  task automatic apply(input in_t v);
    imemReady = v.rdy; hazardStall = v.haz;
    trapReq = v.trap; brTaken = v.br; jalEn = v.jal;
    trapVect = v.tv; brTarget = v.bt; jalTarget = v.jt;
  endtask

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got stall=%b jen=%b jv=%h fif=%b fid=%b req=%b mis=%b, expected stall=%b jen=%b jv=%h fif=%b fid=%b req=%b mis=%b",
               name, act.stall, act.jen, act.jv, act.fif, act.fid, act.req, act.mis,
               exp.stall, exp.jen, exp.jv, exp.fif, exp.fid, exp.req, exp.mis);
    end
  endtask

  // One cycle: drive just after a rising edge, sample on the falling edge,
  // advance the model after the next rising edge.
  task automatic tick(input in_t v, output out_t act, output out_t mexp);
    apply(v);
    @(negedge clk);
    act = sample();
    model_eval(v, mexp);
    @(posedge clk);
    #1;
    model_commit();
  endtask

  // Tick and check against a hand-written expectation.
  task automatic step(input string name, input in_t v, input out_t exp);
    out_t a, m;
    tick(v, a, m);
    chk(name, a, exp);
  endtask

  task automatic sync_reset();
    apply(mki(1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  in_t  IDLE, WAITI;
  out_t RUNQ, RESETV, BOOTV;
  vec_t tbl[11];

  initial begin
    IDLE   = mki(1, 0, 0, 0, 0, 0, 0, 0);
    WAITI  = mki(0, 0, 0, 0, 0, 0, 0, 0);
    RUNQ   = mko(0, 0, 32'h0, 0, 0, 1, 0);
    RESETV = mko(1, 0, 32'h0, 1, 1, 0, 0);
    BOOTV  = RESETV;

    // RUN state, no pending entry at row 0.
    tbl[0]  = '{i: mki(1,0,0,1,0, 0, 32'h100, 0),                 o: mko(0,1,32'h100,1,1,1,0)};
    tbl[1]  = '{i: IDLE,                                           o: RUNQ};
    tbl[2]  = '{i: mki(1,0,1,1,1, 32'h200, 32'h300, 32'h400),     o: mko(0,1,32'h200,1,1,1,0)};
    tbl[3]  = '{i: mki(1,0,0,0,1, 0, 0, 32'h400),                 o: mko(0,1,32'h400,1,0,1,0)};
    tbl[4]  = '{i: mki(1,1,0,0,0, 0, 0, 0),                       o: mko(1,0,32'h0,0,0,1,0)};
    tbl[5]  = '{i: mki(1,1,0,1,0, 0, 32'h80, 0),                  o: mko(0,1,32'h80,1,1,1,0)};
    tbl[6]  = '{i: mki(1,0,0,1,0, 0, 32'h103, 0),                 o: mko(0,1,32'h100,1,1,1,0)};
    tbl[7]  = '{i: IDLE,                                           o: mko(0,0,32'h0,0,0,1,1)};
    tbl[8]  = '{i: IDLE,                                           o: RUNQ};
    tbl[9]  = '{i: mki(1,1,1,0,0, 32'h202, 0, 0),                 o: mko(0,1,32'h200,1,1,1,0)};
    tbl[10] = '{i: IDLE,                                           o: mko(0,0,32'h0,0,0,1,1)};

    apply(IDLE);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", sample(), RESETV);
    reset = 1'b0;

    // Boot: exactly BOOT_DELAY stalled/flushing cycles, then fetch.
    step("boot_c0", IDLE, BOOTV);
    step("boot_c1", IDLE, BOOTV);
    step("boot_run", IDLE, RUNQ);

    for (int k = 0; k < 11; k++) begin
      step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);
    end

    // JAL held across a 3-cycle imem wait, applied on the first ready cycle.
    step("wait_jal_c1", mki(0,0,0,0,1, 0, 0, 32'h40), mko(1,0,0,0,0,1,0));
    step("wait_c2", WAITI, mko(1,0,0,0,0,1,0));
    step("wait_c3", WAITI, mko(1,0,0,0,0,1,0));
    step("wait_apply", IDLE, mko(0,1,32'h40,1,0,1,0));
    step("wait_cleared", IDLE, RUNQ);

    // Pending branch outranks a later JAL; the JAL is dropped.
    step("pbr_cap", mki(0,0,0,1,0, 0, 32'h300, 0), mko(1,0,0,0,0,1,0));
    step("pbr_jal", mki(0,0,0,0,1, 0, 0, 32'h400), mko(1,0,0,0,0,1,0));
    step("pbr_apply", IDLE, mko(0,1,32'h300,1,1,1,0));
    step("pbr_jal_dropped", IDLE, RUNQ);

    // Later trap replaces a pending JAL.
    step("ptr_jal", mki(0,0,0,0,1, 0, 0, 32'h44), mko(1,0,0,0,0,1,0));
    step("ptr_trap", mki(0,0,1,0,0, 32'h500, 0, 0), mko(1,0,0,0,0,1,0));
    step("ptr_apply", IDLE, mko(0,1,32'h500,1,1,1,0));
    step("ptr_empty", IDLE, RUNQ);

    // Pending consumed while a lower live request arrives: the live one is lost.
    step("pcon_cap", mki(0,0,0,1,0, 0, 32'h600, 0), mko(1,0,0,0,0,1,0));
    step("pcon_apply", mki(1,0,0,0,1, 0, 0, 32'h700), mko(0,1,32'h600,1,1,1,0));
    step("pcon_dropped", IDLE, RUNQ);

    // Async reset mid-WAIT with a pending entry.
    step("ar_cap", mki(0,0,0,1,0, 0, 32'h900, 0), mko(1,0,0,0,0,1,0));
    apply(WAITI);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", sample(), RESETV);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step("ar_boot0", IDLE, BOOTV);
    step("ar_boot1", IDLE, BOOTV);
    step("ar_run0", IDLE, RUNQ);
    step("ar_run1", IDLE, RUNQ);

    // Randomized traffic against the reference model, with periodic resets.
    for (int n = 0; n < 2000; n++) begin
      in_t  v;
      out_t a, m;
      if (n % 500 == 250) sync_reset();
      v.rdy  = ($urandom_range(0, 3) != 0);
      v.haz  = ($urandom_range(0, 3) == 0);
      v.trap = ($urandom_range(0, 9) == 0);
      v.br   = ($urandom_range(0, 6) == 0);
      v.jal  = ($urandom_range(0, 5) == 0);
      v.tv   = $urandom;
      v.bt   = $urandom;
      v.jt   = $urandom;
      tick(v, a, m);
      chk($sformatf("rand%0d", n), a, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller for the program counter register. It drives the PC's `stall`, `jumpEn` and `jumpVect` inputs. It arbitrates redirect requests from three sources: trap, EX-stage branch and ID-stage jump. It merges load-use hazard and instruction-memory wait conditions into one stall. It also holds a redirect that arrives while the fetch is stalled, so no redirect is lost. It sits between the hazard unit, the branch/jump resolution logic and the PC/IF stage.

## Interface
- `BOOT_DELAY`, 2: cycles after reset release before the first fetch (1..15).
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `imemReady` input 1: instruction memory can accept or has completed the fetch at the current PC.
- `hazardStall` input 1: load-use hazard from the hazard unit.
- `trapReq` input 1: trap/exception redirect request.
- `trapVect` input 32: trap handler address.
- `brTaken` input 1: EX-stage taken branch or mispredict.
- `brTarget` input 32: EX branch target.
- `jalEn` input 1: ID-stage unconditional jump.
- `jalTarget` input 32: ID jump target.
- `stall` output 1: to PC `stall`.
- `jumpEn` output 1: to PC `jumpEn`.
- `jumpVect` output 32: to PC `jumpVect`.
- `flushIF` output 1: kill the IF/ID instruction.
- `flushID` output 1: kill the ID/EX instruction.
- `imemReq` output 1: fetch request to instruction memory.
- `misalignErr` output 1: one-cycle pulse when an accepted target has bits [1:0] ≠ 0.

## Operation
- **States:**
  - BOOT: counter loaded with `BOOT_DELAY`. It decrements each cycle. At 0 the block moves to RUN.
  - RUN: `imemReady`=1.
  - WAIT: `imemReady`=0. The block returns to RUN on the cycle `imemReady` returns to 1.
- **Priority:** `trapReq` > `brTaken` > `jalEn`. The live winner is the highest-priority asserted request.
- **Pending register** (valid, 2-bit source, 32-bit target):
  - Captured when a live request exists and `stall`=1 from imem wait or BOOT.
  - A new live request replaces the pending entry only if its priority is ≥ the pending priority.
  - A lower-priority request is dropped, because it is wrong-path.
- **Effective request:**
  - The live winner if its priority is ≥ the pending priority.
  - Otherwise the pending entry.
- **stall** = BOOT | !`imemReady` | (`hazardStall` & no effective request).
  - A redirect overrides the hazard stall, since the stalled load is wrong-path.
- **jumpEn** = effective request valid & `stall`=0.
- **jumpVect** = effective target with bits [1:0] forced to 0. It is 0 when `jumpEn`=0.
- **Consuming a pending entry:** on a cycle with `jumpEn`=1, the pending entry is cleared. If a live request arrives in that same cycle and does not win, it is dropped.
- **flushIF** = `jumpEn`, or state BOOT.
- **flushID** = `jumpEn` & source ∈ {trap, branch}, or state BOOT.
- **imemReq** = state ≠ BOOT.
- **misalignErr:** registered; it asserts the cycle after a `jumpEn` whose raw target[1:0] ≠ 0.

## Timing
- **Reset value** (asynchronous, immediate):
  - state BOOT, counter = `BOOT_DELAY`, pending valid = 0.
  - `stall`=1, `jumpEn`=0, `jumpVect`=0, `flushIF`=1, `flushID`=1, `imemReq`=0, `misalignErr`=0.
- **Boot:** the first non-stalled cycle is exactly `BOOT_DELAY` cycles after `reset` deasserts.
- **Redirect latency:**
  - An unstalled request asserts `jumpEn` combinationally in the same cycle.
  - The PC equals the target at the next rising edge.
- **Stalled request:** it is applied in the first cycle where `stall`=0. The requester need only pulse it for one cycle.
- **Same-cycle collisions:** simultaneous requests are resolved by priority. Only the winner is captured or applied.
- **Reset mid-WAIT or with a pending entry:** the pending entry is discarded and the block returns to BOOT.
- All outputs except `misalignErr` are combinational from state, pending and inputs. No combinational path exists from `jumpEn` back into any input.

## Structure
- **Shared package `pc_ctrl_pkg`:**
  - State encoding localparams: BOOT=2'd0, RUN=2'd1, WAIT=2'd2.
  - Source codes: NONE=0, JAL=1, BR=2, TRAP=3. The numeric order is the priority.
  - Reset vector constant 32'h0000_0000.
- **Sub-module `redirect_arb`:** combinational 3-way priority select with pending compare, producing source and target.
- The FSM, boot counter and pending register stay in the top module.

## Test plan
- **Reset/boot:** `BOOT_DELAY`=2, release `reset` → `stall`=1 and flushes=1 for 2 cycles, then `stall`=0 and `imemReq`=1.
- **Unstalled branch:** `brTaken`=1 with `brTarget`=32'h100 → same cycle `jumpEn`=1, `jumpVect`=32'h100, `flushIF`=`flushID`=1.
- **Redirect during imem wait:**
  - `imemReady`=0 for 3 cycles; pulse `jalEn` with `jalTarget`=32'h40 in cycle 1 → `jumpEn`=0 while waiting.
  - Then `jumpEn`=1 with 32'h40 the first ready cycle; pending cleared after.
- **Priority:**
  - `trapReq`, `brTaken` and `jalEn` together, with targets 32'h200/32'h300/32'h400 → `jumpVect`=32'h200.
  - Pending branch 32'h300 followed by `jalEn` during the stall → 32'h300 applied and the JAL dropped.
- **Hazard override:** `hazardStall`=1 alone → `stall`=1; `hazardStall`=1 with `brTaken` (target 32'h80) → `stall`=0, `jumpEn`=1.
- **Misalign and async reset:**
  - `brTarget`=32'h103 → `jumpVect`=32'h100 and `misalignErr` pulses the next cycle.
  - Assert `reset` mid-WAIT with a pending entry → outputs reach their reset values immediately, and no jump occurs after boot.
